// File: rtl/temp_bank_ctrl_mc_if.sv
// Sample stream from the time-multiplexed ADC front end into the bank controller.
interface temp_bank_ctrl_mc_if #(
   parameter int ADC_W = 12,
   parameter int CH_W  = 3
);
   logic             s_valid;
   logic [CH_W-1:0]  s_ch;
   logic [ADC_W-1:0] s_code;

   modport master (output s_valid, output s_ch, output s_code);
   modport slave  (input  s_valid, input  s_ch, input  s_code);
endinterface

// File: rtl/temp_bank_ctrl_mc.sv
// Multi-sensor temperature bank controller: per-channel moving-average filters,
// hottest-channel tracking, threshold/hysteresis/dwell bank regulation with a
// force override, and a one-cycle anneal_reset pulse on every bank change.
module temp_bank_ctrl_mc #(
   parameter int ADC_W       = 12,
   parameter int NUM_SENSORS = 4,
   parameter int NUM_BANKS   = 3,
   parameter int LOG2_DEPTH  = 3,
   parameter int HYST        = 41,
   parameter int DWELL       = 4,
   parameter int INIT_CODE   = 1024,
   parameter int INIT_BANK   = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   temp_bank_ctrl_mc_if.slave               smp,
   input  logic [(NUM_BANKS-1)*ADC_W-1:0]   thr_cfg_i,
   input  logic                             force_en_i,
   input  logic [2:0]                       force_bank_i,
   output logic [2:0]                       bank_sel_o,
   output logic                             bank_changed_o,
   output logic                             anneal_reset_o,
   output logic [ADC_W-1:0]                 temp_max_o,
   output logic                             err_ch_o,
   output logic                             cfg_err_o
);

   localparam int CH_W  = $clog2(NUM_SENSORS) + 1;
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = ADC_W + LOG2_DEPTH;

   localparam logic [ADC_W-1:0] INIT_W   = ADC_W'(INIT_CODE);
   localparam logic [SUM_W-1:0] SUM_INIT = SUM_W'(INIT_CODE) << LOG2_DEPTH;
   localparam logic [ADC_W-1:0] HYST_A   = ADC_W'(HYST);
   localparam logic [2:0]       BANK_MAX = 3'(NUM_BANKS - 1);
   localparam logic [7:0]       DWELL_C  = 8'(DWELL);

   // Direction of the current run of qualifying evaluations.
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_e;

   logic                 s_ok;
   logic [ADC_W-1:0]     filt_w [NUM_SENSORS];
   logic [ADC_W-1:0]     max_c;
   logic [ADC_W-1:0]     thr_w [8];
   logic                 cfg_bad_c;
   logic [ADC_W:0]       up_sum;
   logic [ADC_W-1:0]     up_lim;
   logic [ADC_W-1:0]     thr_lo;
   logic [ADC_W-1:0]     dn_lim;
   logic                 up_hit;
   logic                 dn_hit;

   logic [2:0]           bank_q, bank_d;
   dir_e                 dir_q, dir_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 chg_q;
   logic                 err_q;
   logic                 eval_q;
   logic                 cfg_err_q;
   logic [ADC_W-1:0]     tmax_q;

   assign s_ok = smp.s_valid && (smp.s_ch < CH_W'(NUM_SENSORS));

   // Per-channel circular buffer with a running sum; the filtered value is the
   // truncated mean, refreshed in the same edge that accepts the sample.
   for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_ch
      logic [ADC_W-1:0]      buf_q [DEPTH];
      logic [SUM_W-1:0]      sum_q;
      logic [SUM_W-1:0]      sum_d;
      logic [LOG2_DEPTH-1:0] idx_q;
      logic [ADC_W-1:0]      filt_q;
      logic                  hit;

      assign hit   = s_ok && (smp.s_ch == CH_W'(gi));
      assign sum_d = sum_q - SUM_W'(buf_q[idx_q]) + SUM_W'(smp.s_code);
      assign filt_w[gi] = filt_q;

      // Replace the oldest entry and advance the write pointer on an accepted sample.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= INIT_W;
            sum_q  <= SUM_INIT;
            idx_q  <= '0;
            filt_q <= INIT_W;
         end else if (hit) begin
            buf_q[idx_q] <= smp.s_code;
            sum_q        <= sum_d;
            idx_q        <= idx_q + 1'b1;
            filt_q       <= sum_d[SUM_W-1:LOG2_DEPTH];
         end
      end
   end

   // Hottest filtered channel.
   always_comb begin
      max_c = filt_w[0];
      for (int i = 1; i < NUM_SENSORS; i++) begin
         if (filt_w[i] > max_c) max_c = filt_w[i];
      end
   end

   // Unpack thresholds into a fixed 8-entry table so bank-indexed lookups never leave range.
   for (genvar gi = 0; gi < 8; gi++) begin : g_thr
      if (gi < NUM_BANKS - 1) begin : g_used
         assign thr_w[gi] = thr_cfg_i[gi*ADC_W +: ADC_W];
      end else begin : g_pad
         assign thr_w[gi] = '0;
      end
   end

   // Thresholds must be strictly ascending.
   always_comb begin
      cfg_bad_c = 1'b0;
      for (int j = 0; j < NUM_BANKS - 2; j++) begin
         if (thr_w[j+1] <= thr_w[j]) cfg_bad_c = 1'b1;
      end
   end

   // Saturated hysteresis limits around the boundaries above and below the current bank.
   always_comb begin
      up_sum = {1'b0, thr_w[bank_q]} + {1'b0, HYST_A};
      up_lim = up_sum[ADC_W] ? '1 : up_sum[ADC_W-1:0];
      thr_lo = thr_w[bank_q - 3'd1];
      dn_lim = (thr_lo < HYST_A) ? '0 : (thr_lo - HYST_A);
      up_hit = (bank_q < BANK_MAX) && (max_c > up_lim);
      dn_hit = (bank_q != 3'd0) && (max_c < dn_lim);
   end

   // Bank regulation: force has priority, a bad config freezes, otherwise dwell-debounced steps.
   always_comb begin
      bank_d = bank_q;
      dir_d  = dir_q;
      cnt_d  = cnt_q;
      if (force_en_i) begin
         bank_d = (force_bank_i > BANK_MAX) ? BANK_MAX : force_bank_i;
         dir_d  = DIR_NONE;
         cnt_d  = '0;
      end else if (cfg_err_q) begin
         dir_d = DIR_NONE;
         cnt_d = '0;
      end else if (eval_q) begin
         if (up_hit) begin
            cnt_d = (dir_q == DIR_UP) ? cnt_q + 8'd1 : 8'd1;
            dir_d = DIR_UP;
         end else if (dn_hit) begin
            cnt_d = (dir_q == DIR_DN) ? cnt_q + 8'd1 : 8'd1;
            dir_d = DIR_DN;
         end else begin
            cnt_d = '0;
            dir_d = DIR_NONE;
         end
         if (cnt_d == DWELL_C) begin
            bank_d = (dir_d == DIR_UP) ? bank_q + 3'd1 : bank_q - 3'd1;
            cnt_d  = '0;
            dir_d  = DIR_NONE;
         end
      end
   end

   // State, pulses and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q    <= 3'(INIT_BANK);
         dir_q     <= DIR_NONE;
         cnt_q     <= '0;
         chg_q     <= 1'b0;
         err_q     <= 1'b0;
         eval_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         tmax_q    <= INIT_W;
      end else begin
         bank_q    <= bank_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         chg_q     <= (bank_d != bank_q);
         err_q     <= smp.s_valid && !s_ok;
         eval_q    <= s_ok;
         cfg_err_q <= cfg_bad_c;
         tmax_q    <= max_c;
      end
   end

   assign bank_sel_o     = bank_q;
   assign bank_changed_o = chg_q;
   assign anneal_reset_o = chg_q;
   assign temp_max_o     = tmax_q;
   assign err_ch_o       = err_q;
   assign cfg_err_o      = cfg_err_q;

endmodule
